// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = WIDTH;

  localparam logic [WIDTH-1:0] DIVZ_LO = '1;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  // op[1] selects divide, op[0] selects the unsigned variant
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used both for operand magnitudes
// and for restoring the sign of the final result.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  // negate when requested, otherwise pass through
  always_comb begin
    dout = neg ? (~din + W'(1)) : din;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One radix-2 step per cycle on operand magnitudes, then a sign fixup.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO accepted here
// CALC  | WIDTH shift-add or restoring-divide steps
// FIXUP | apply signs, write HI/LO, pulse done
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER);

  state_t           state;
  logic             is_div;
  logic             sa;
  logic             sb;
  logic             divz;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // operand signs only matter for the signed ops
  always_comb begin
    a_neg = op_is_signed(op) & a[WIDTH-1];
    b_neg = op_is_signed(op) & b[WIDTH-1];
  end

  muldiv_signfix #(.W(WIDTH)) u_mag_a (.neg(a_neg), .din(a), .dout(mag_a));
  muldiv_signfix #(.W(WIDTH)) u_mag_b (.neg(b_neg), .din(b), .dout(mag_b));

  // acc holds {partial product, multiplier} for multiply and
  // {unused, dividend/quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
    div_shift = {rem, acc[WIDTH-1]};
    div_diff  = div_shift - {2'b00, mb};
    div_ok    = ~div_diff[WIDTH+1];
  end

  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (.neg(sa ^ sb), .din(acc), .dout(prod_fix));
  muldiv_signfix #(.W(WIDTH)) u_fix_quo (.neg(sa ^ sb), .din(acc[WIDTH-1:0]), .dout(quo_fix));
  muldiv_signfix #(.W(WIDTH)) u_fix_rem (.neg(sa), .din(rem[WIDTH-1:0]), .dout(rem_fix));

  // sequencing FSM, datapath registers and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      divz   <= 1'b0;
      ma     <= '0;
      mb     <= '0;
      acc    <= '0;
      rem    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op_is_div(op);
            sa     <= a_neg;
            sb     <= b_neg;
            divz   <= op_is_div(op) & (b == '0);
            ma     <= mag_a;
            mb     <= mag_b;
            acc    <= op_is_div(op) ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            rem    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          if (is_div) begin
            rem <= div_ok ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ok};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= FIXUP;
        end
        FIXUP: begin
          if (is_div) begin
            // zero divisor: restoring steps leave rem=|a|, so rem_fix is a
            lo <= divz ? DIVZ_LO : quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: {HI, LO} from architectural MIPS semantics
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    if (o == OP_MULT) begin
      res = longint'($signed(x)) * longint'($signed(y));
    end else if (o == OP_MULTU) begin
      res = {32'b0, x} * {32'b0, y};
    end else if (y == 32'd0) begin
      res = {x, 32'hFFFF_FFFF};
    end else begin
      if (o == OP_DIV) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
      end else begin
        sx = longint'({32'b0, x});
        sy = longint'({32'b0, y});
      end
      q = sx / sy;
      r = sx % sy;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  // launch at the current negedge, return at the negedge where done is seen
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] rh, output logic [31:0] rl, output int lat);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    lat = 0; n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) lat++;
      n++;
      @(negedge clk);
    end
    if (n >= 200) lat = -1;
    rh = hi; rl = lo;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #12;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_total++; if (hi !== 32'd0) $display("FAIL reset_hi got %h want 0", hi); else n_pass++;
    n_total++; if (lo !== 32'd0) $display("FAIL reset_lo got %h want 0", lo); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult_signed;
    logic [31:0] rh, rl;
    int lat;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, rh, rl, lat);
    n_total++; if (lat != 33) $display("FAIL mult_latency got %0d want 33", lat); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mult_busy_at_done got %b want 0", busy); else n_pass++;
    n_total++; if (rh !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h want ffffffff", rh); else n_pass++;
    n_total++; if (rl !== 32'hFFFF_FFF1) $display("FAIL mult_lo got %h want fffffff1", rl); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b0) $display("FAIL done_one_cycle got %b want 0", done); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rh, rl;
    int lat;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, lat);
    n_total++; if (rh !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h want fffffffe", rh); else n_pass++;
    n_total++; if (rl !== 32'h0000_0001) $display("FAIL multu_lo got %h want 00000001", rl); else n_pass++;
    issue(OP_DIVU, 32'd100, 32'd7, rh, rl, lat);
    n_total++; if (lat != 33) $display("FAIL b2b_latency got %0d want 33", lat); else n_pass++;
    n_total++; if (rl !== 32'h0000_000E) $display("FAIL divu_lo got %h want 0000000e", rl); else n_pass++;
    n_total++; if (rh !== 32'h0000_0002) $display("FAIL divu_hi got %h want 00000002", rh); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_div_signed;
    logic [31:0] rh, rl;
    int lat;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, rh, rl, lat);
    n_total++; if (rl !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h want fffffffd", rl); else n_pass++;
    n_total++; if (rh !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h want ffffffff", rh); else n_pass++;
    @(negedge clk);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl, lat);
    n_total++; if (rl !== 32'h8000_0000) $display("FAIL div_ovf_lo got %h want 80000000", rl); else n_pass++;
    n_total++; if (rh !== 32'h0000_0000) $display("FAIL div_ovf_hi got %h want 00000000", rh); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    logic [31:0] rh, rl;
    int lat;
    issue(OP_DIVU, 32'h1234_5678, 32'd0, rh, rl, lat);
    n_total++; if (lat != 33) $display("FAIL divz_latency got %0d want 33", lat); else n_pass++;
    n_total++; if (rl !== 32'hFFFF_FFFF) $display("FAIL divz_lo got %h want ffffffff", rl); else n_pass++;
    n_total++; if (rh !== 32'h1234_5678) $display("FAIL divz_hi got %h want 12345678", rh); else n_pass++;
    @(negedge clk);
    issue(OP_DIV, 32'hFFFF_FF00, 32'd0, rh, rl, lat);
    n_total++; if (rl !== 32'hFFFF_FFFF) $display("FAIL divz_s_lo got %h want ffffffff", rl); else n_pass++;
    n_total++; if (rh !== 32'hFFFF_FF00) $display("FAIL divz_s_hi got %h want ffffff00", rh); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_ignore_while_busy;
    int c;
    // preload HI/LO, both strobes together
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_2222;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    n_total++; if (hi !== 32'h1111_2222) $display("FAIL mthi_both got %h want 11112222", hi); else n_pass++;
    n_total++; if (lo !== 32'h1111_2222) $display("FAIL mtlo_both got %h want 11112222", lo); else n_pass++;
    // strobe alongside an accepted start must be dropped
    start = 1'b1; op = OP_MULT; a = 32'd6; b = 32'd7; hi_we = 1'b1; wdata = 32'hAAAA_AAAA;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    c = 1;
    while (done !== 1'b1 && c < 200) begin
      if (c == 5) begin
        n_total++; if (hi !== 32'h1111_2222) $display("FAIL calc_hold_hi got %h want 11112222", hi); else n_pass++;
        n_total++; if (lo !== 32'h1111_2222) $display("FAIL calc_hold_lo got %h want 11112222", lo); else n_pass++;
      end
      if (c == 10) begin start = 1'b1; op = OP_MULTU; a = 32'd100; b = 32'd200; end
      if (c == 11) start = 1'b0;
      if (c == 12) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; end
      if (c == 13) begin hi_we = 1'b0; lo_we = 1'b0; end
      c++;
      @(negedge clk);
    end
    n_total++; if (c != 34) $display("FAIL busy_ignore_latency got %0d want 34", c); else n_pass++;
    n_total++; if (hi !== 32'd0) $display("FAIL busy_ignore_hi got %h want 00000000", hi); else n_pass++;
    n_total++; if (lo !== 32'd42) $display("FAIL busy_ignore_lo got %h want 0000002a", lo); else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL late_start_ignored got busy %b want 0", busy); else n_pass++;
    lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    lo_we = 1'b0;
    n_total++; if (lo !== 32'h55) $display("FAIL mtlo got %h want 00000055", lo); else n_pass++;
    n_total++; if (hi !== 32'd0) $display("FAIL mtlo_hi_unchanged got %h want 00000000", hi); else n_pass++;
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] rh, rl;
    int lat;
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL midrst_done got %b want 0", done); else n_pass++;
    n_total++; if (hi !== 32'd0) $display("FAIL midrst_hi got %h want 0", hi); else n_pass++;
    n_total++; if (lo !== 32'd0) $display("FAIL midrst_lo got %h want 0", lo); else n_pass++;
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_quiet got busy %b done %b want 0 0", busy, done); else n_pass++;
    issue(OP_MULTU, 32'd2, 32'd3, rh, rl, lat);
    n_total++; if (rl !== 32'd6) $display("FAIL post_rst_lo got %h want 00000006", rl); else n_pass++;
    n_total++; if (rh !== 32'd0) $display("FAIL post_rst_hi got %h want 00000000", rh); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] rh, rl, x, y;
    logic [1:0]  o;
    logic [63:0] exp;
    int lat;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: x = 32'h8000_0000;
        3: y = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp = model(o, x, y);
      issue(o, x, y, rh, rl, lat);
      n_total++;
      if (lat != 33 || rh !== exp[63:32] || rl !== exp[31:0])
        $display("FAIL random[%0d] op=%0d a=%h b=%h got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=33",
                 i, o, x, y, rh, rl, lat, exp[63:32], exp[31:0]);
      else n_pass++;
      // sometimes chain back-to-back, otherwise idle a cycle
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_mult_signed;
    test_back_to_back;
    test_div_signed;
    test_div_zero;
    test_ignore_while_busy;
    test_reset_mid_op;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU on two 32-bit operands supplied beside the ALU. The 64-bit result is held in architectural HI/LO registers, which the MFHI/MFLO path reads. MTHI/MTLO write the same registers. The unit is multi-cycle: the pipeline stalls on busy.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits; iteration count = WIDTH

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  launch operation; sampled only when busy=0
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  in  WIDTH  rs operand (multiplicand / dividend)
b  in  WIDTH  rt operand (multiplier / divisor)
hi_we  in  1  MTHI write strobe
lo_we  in  1  MTLO write strobe
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in progress
done  out  1  one-cycle pulse; HI/LO valid with new result
hi  out  WIDTH  HI register (MULT upper product / DIV remainder)
lo  out  WIDTH  LO register (MULT lower product / DIV quotient)

Behaviour:
- One clock; reset is asynchronous and active-low. With rst_n=0: state=IDLE, busy=0, done=0, hi=0, lo=0, all internal datapath registers 0. Reset mid-operation aborts the operation; no partial result is kept.
- FSM states: IDLE, CALC, FIXUP.
- IDLE -> CALC on edge E0 with start=1. On that edge the unit latches op, the sign flags sa=a[31] and sb=b[31] (signed ops only, else 0), the magnitudes |a| and |b|, and sets counter=0 and busy=1.
- CALC runs one radix-2 step per edge, on edges E1..E32. It goes to FIXUP when counter reaches WIDTH-1.
  - Multiply: shift-add on magnitudes, with a 64-bit accumulator.
  - Divide: restoring division; remainder register WIDTH+1 bits.
- FIXUP happens on edge E33:
  - MULT: negate the 64-bit product if sa^sb.
  - DIV: quotient negated if sa^sb; remainder negated if sa.
  - HI/LO are written, done=1 for exactly one cycle, busy=0, and the FSM returns to IDLE.
- Latency: busy is high for 33 cycles; done is high in the cycle after E33. Back-to-back is allowed: start may be asserted in the done cycle.
- Divide by zero (b=0, any signedness): LO=32'hFFFF_FFFF, HI=a (the original operand). Latency is unchanged.
- DIV overflow (0x8000_0000 / 0xFFFF_FFFF): LO=0x8000_0000, HI=0. This falls out of the magnitude datapath naturally; no special case is needed.
- start while busy=1: ignored; no effect on the operation in flight.
- MTHI/MTLO:
  - When busy=0 and start=0, hi_we and lo_we write wdata on the next edge; both may assert together.
  - Strobes while busy, or in the same cycle as an accepted start, are dropped.
- hi and lo change only on an accepted MTHI/MTLO, at FIXUP, or on reset. They hold their old values throughout CALC.
- The op encoding is fixed; no illegal values exist.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum {IDLE, CALC, FIXUP}
  - constant ITER = WIDTH
  - divide-by-zero constant DIVZ_LO = all-ones
- Sub-module muldiv_signfix: combinational conditional two's-complement negate, parameterised width. It is used for operand magnitude at start (WIDTH) and for result fixup (2*WIDTH and WIDTH).

Test Plan:
- MULT a=0xFFFF_FFFD (-3), b=5 -> after 33 busy cycles done pulses; HI=0xFFFF_FFFF, LO=0xFFFF_FFF1.
- MULTU a=b=0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001. Then DIVU a=100, b=7 issued in the done cycle -> LO=0x0000_000E, HI=0x0000_0002.
- DIV a=0xFFFF_FFF9 (-7), b=2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. Then DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- DIVU a=0x1234_5678, b=0 -> LO=0xFFFF_FFFF, HI=0x1234_5678, with done at the normal latency.
- During MULT 6*7: start with new operands at cycle 10 and hi_we/wdata=0xDEAD_BEEF at cycle 12. Both are ignored -> HI=0, LO=42. When idle, lo_we with wdata=0x55 -> LO=0x55 next edge, HI unchanged.
- Drop rst_n at cycle 15 of a DIV -> busy=0, done=0, HI=LO=0 immediately, without waiting for a clock edge. After release, a fresh MULTU 2*3 gives LO=6.
